// File: rtl/sram_port_arbiter_if.sv
// Requester and SRAM-side signals of the shared single-port SRAM arbiter.
// The slave modport is the arbiter; the master modport is the pipeline plus SRAM model.
interface sram_port_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output sram_en, sram_we, sram_addr, sram_wdata,
        input  sram_rdata
    );

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  sram_en, sram_we, sram_addr, sram_wdata,
        output sram_rdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one synchronous single-port SRAM between IF and EX/MEM with data priority.
// Optional macro ARB_STARVE_GUARD_EN: force an IF grant after STARVE_LIMIT data wins.
module sram_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    sram_port_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {R_IDLE, R_INST, R_DATA} resp_e;

    resp_e state_q, state_d;
    logic  gnt_inst, gnt_data, force_inst;

    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("STARVE_LIMIT must be at least 1");
    end

`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned CW = (STARVE_LIMIT < 8) ? 3 : $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;

    assign force_inst = bus.inst_req && bus.data_req && (starve_cnt_q == CW'(STARVE_LIMIT));

    // Counts data wins only while IF is actually waiting
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!bus.inst_req || gnt_inst)
            starve_cnt_d = '0;
        else if (gnt_data)
            starve_cnt_d = starve_cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) starve_cnt_q <= '0;
        else       starve_cnt_q <= starve_cnt_d;
    end
`else
    assign force_inst = 1'b0;
`endif

    assign gnt_data = !reset && bus.data_req && !force_inst;
    assign gnt_inst = !reset && bus.inst_req && !gnt_data;

    always_comb begin
        state_d = R_IDLE;
        if (gnt_data)      state_d = R_DATA;
        else if (gnt_inst) state_d = R_INST;
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= R_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        bus.inst_addr_ok = 1'b0;
        bus.data_addr_ok = 1'b0;
        bus.sram_en      = 1'b0;
        bus.sram_we      = 4'h0;
        bus.sram_addr    = 32'h0;
        bus.sram_wdata   = 32'h0;
        if (gnt_data) begin
            bus.data_addr_ok = 1'b1;
            bus.sram_en      = 1'b1;
            bus.sram_addr    = bus.data_addr;
            bus.sram_we      = bus.data_wr ? bus.data_wstrb : 4'h0;
            bus.sram_wdata   = bus.data_wdata;
        end else if (gnt_inst) begin
            bus.inst_addr_ok = 1'b1;
            bus.sram_en      = 1'b1;
            bus.sram_addr    = bus.inst_addr;
        end
    end

    // Response is owned by whoever was granted last cycle; reset squashes it
    always_comb begin
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = 32'h0;
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = 32'h0;
        if (!reset) begin
            case (state_q)
                R_INST: begin
                    bus.inst_data_ok = 1'b1;
                    bus.inst_rdata   = bus.sram_rdata;
                end
                R_DATA: begin
                    bus.data_data_ok = 1'b1;
                    bus.data_rdata   = bus.sram_rdata;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a small behavioural SRAM model.
module tb_sram_port_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    sram_port_arbiter_if bus ();

    sram_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // SRAM: 256 words indexed by addr[9:2], read data one cycle after the access
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (bus.sram_en) begin
            bus.sram_rdata <= mem[bus.sram_addr[9:2]];
            for (int b = 0; b < 4; b++)
                if (bus.sram_we[b]) mem[bus.sram_addr[9:2]][b*8 +: 8] <= bus.sram_wdata[b*8 +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.inst_req   = 1'b0;
        bus.inst_addr  = 32'h0;
        bus.data_req   = 1'b0;
        bus.data_wr    = 1'b0;
        bus.data_wstrb = 4'h0;
        bus.data_addr  = 32'h0;
        bus.data_wdata = 32'h0;
    endtask

    task automatic drv_data(input logic wr, input logic [3:0] strb, input logic [31:0] addr,
                            input logic [31:0] wdata);
        bus.data_req   = 1'b1;
        bus.data_wr    = wr;
        bus.data_wstrb = strb;
        bus.data_addr  = addr;
        bus.data_wdata = wdata;
    endtask

    logic [31:0] alt_addr [6];
    logic [31:0] alt_val  [6];
    int          n_inst;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0]   = 32'h02800C0C;   // 0x1C000000
        mem[1]   = 32'h00000001;   // 0x1C000004
        mem[128] = 32'h20000200;
        mem[129] = 32'h20000204;
        mem[130] = 32'h20000208;
        alt_addr = '{32'h1C000010, 32'h00000300, 32'h1C000014, 32'h00000304, 32'h1C000018, 32'h00000308};
        alt_val  = '{32'h11110004, 32'h220000C0, 32'h11110005, 32'h220000C1, 32'h11110006, 32'h220000C2};
        mem[4] = alt_val[0]; mem[192] = alt_val[1];
        mem[5] = alt_val[2]; mem[193] = alt_val[3];
        mem[6] = alt_val[4]; mem[194] = alt_val[5];
        bus.sram_rdata = 32'h0;

        // Reset with both requests present: nothing may be granted
        idle();
        reset = 1'b1;
        @(negedge clk);
        bus.inst_req = 1'b1; bus.inst_addr = 32'h1C000000;
        drv_data(1'b1, 4'hF, 32'h100, 32'h12345678);
        #1;
        chk("rst_sram_en",  {31'h0, bus.sram_en},      32'h0);
        chk("rst_inst_aok", {31'h0, bus.inst_addr_ok}, 32'h0);
        chk("rst_data_aok", {31'h0, bus.data_addr_ok}, 32'h0);
        chk("rst_sram_we",  {28'h0, bus.sram_we},      32'h0);
        step();
        idle();
        reset = 1'b0;
        #1;
        chk("post_rst_iok", {31'h0, bus.inst_data_ok}, 32'h0);
        chk("post_rst_dok", {31'h0, bus.data_data_ok}, 32'h0);
        step();

        // Single IF read
        bus.inst_req = 1'b1; bus.inst_addr = 32'h1C000000;
        #1;
        chk("if_aok",   {31'h0, bus.inst_addr_ok}, 32'h1);
        chk("if_en",    {31'h0, bus.sram_en},      32'h1);
        chk("if_we",    {28'h0, bus.sram_we},      32'h0);
        chk("if_addr",  bus.sram_addr,             32'h1C000000);
        step();
        idle();
        #1;
        chk("if_dok",   {31'h0, bus.inst_data_ok}, 32'h1);
        chk("if_rdata", bus.inst_rdata,            32'h02800C0C);
        chk("if_ddok",  {31'h0, bus.data_data_ok}, 32'h0);
        chk("if_drd0",  bus.data_rdata,            32'h0);
        step();

        // Store then load at 0x100
        drv_data(1'b1, 4'hF, 32'h100, 32'hDEADBEEF);
        #1;
        chk("st_aok",   {31'h0, bus.data_addr_ok}, 32'h1);
        chk("st_we",    {28'h0, bus.sram_we},      32'hF);
        chk("st_wdata", bus.sram_wdata,            32'hDEADBEEF);
        chk("st_addr",  bus.sram_addr,             32'h100);
        step();
        drv_data(1'b0, 4'hF, 32'h100, 32'h0);
        #1;
        chk("ld_we",    {28'h0, bus.sram_we},      32'h0);
        chk("st_dok",   {31'h0, bus.data_data_ok}, 32'h1);
        step();
        idle();
        #1;
        chk("ld_dok",   {31'h0, bus.data_data_ok}, 32'h1);
        chk("ld_rdata", bus.data_rdata,            32'hDEADBEEF);
        chk("ld_iok",   {31'h0, bus.inst_data_ok}, 32'h0);
        step();

        // Partial store: low half only
        drv_data(1'b1, 4'b0011, 32'h100, 32'h11223344);
        #1;
        chk("pst_we",   {28'h0, bus.sram_we},      32'h3);
        step();
        drv_data(1'b0, 4'b0011, 32'h100, 32'h0);
        step();
        idle();
        #1;
        chk("pld_rdata", bus.data_rdata,           32'hDEAD3344);
        step();

        // Conflict: data wins three times, IF waits, then IF gets the port
        bus.inst_req = 1'b1; bus.inst_addr = 32'h1C000004;
        for (int k = 0; k < 3; k++) begin
            drv_data(1'b0, 4'h0, 32'h200 + 32'(4 * k), 32'h0);
            #1;
            chk("cf_daok",  {31'h0, bus.data_addr_ok}, 32'h1);
            chk("cf_iaok",  {31'h0, bus.inst_addr_ok}, 32'h0);
            chk("cf_addr",  bus.sram_addr,             32'h200 + 32'(4 * k));
            if (k > 0) chk("cf_rdata", bus.data_rdata, 32'h20000200 + 32'(4 * (k - 1)));
            step();
        end
        bus.data_req = 1'b0;
        #1;
        chk("cf_iaok4", {31'h0, bus.inst_addr_ok}, 32'h1);
        chk("cf_addr4", bus.sram_addr,             32'h1C000004);
        chk("cf_dok4",  {31'h0, bus.data_data_ok}, 32'h1);
        chk("cf_rd4",   bus.data_rdata,            32'h20000208);
        step();
        idle();
        #1;
        chk("cf_iok5",  {31'h0, bus.inst_data_ok}, 32'h1);
        chk("cf_ird5",  bus.inst_rdata,            32'h00000001);
        chk("cf_dok5",  {31'h0, bus.data_data_ok}, 32'h0);
        step();

        // Alternating back-to-back IF / data grants
        for (int k = 0; k <= 6; k++) begin
            idle();
            if (k < 6) begin
                if (k % 2 == 0) begin bus.inst_req = 1'b1; bus.inst_addr = alt_addr[k]; end
                else drv_data(1'b0, 4'h0, alt_addr[k], 32'h0);
            end
            #1;
            if (k < 6) begin
                chk("alt_iaok", {31'h0, bus.inst_addr_ok}, {31'h0, k % 2 == 0});
                chk("alt_daok", {31'h0, bus.data_addr_ok}, {31'h0, k % 2 == 1});
            end
            if (k > 0) begin
                chk("alt_iok", {31'h0, bus.inst_data_ok}, {31'h0, (k - 1) % 2 == 0});
                chk("alt_dok", {31'h0, bus.data_data_ok}, {31'h0, (k - 1) % 2 == 1});
                if ((k - 1) % 2 == 0) chk("alt_ird", bus.inst_rdata, alt_val[k - 1]);
                else                  chk("alt_drd", bus.data_rdata, alt_val[k - 1]);
            end else begin
                chk("alt_iok0", {31'h0, bus.inst_data_ok}, 32'h0);
            end
            step();
        end

        // Both held for six cycles: starvation guard decides whether IF gets in
        n_inst = 0;
        bus.inst_req = 1'b1; bus.inst_addr = 32'h1C000000;
        drv_data(1'b0, 4'h0, 32'h200, 32'h0);
        for (int k = 0; k < 6; k++) begin
            #1;
`ifdef ARB_STARVE_GUARD_EN
            chk("sv_iaok", {31'h0, bus.inst_addr_ok}, {31'h0, k == 4});
            chk("sv_daok", {31'h0, bus.data_addr_ok}, {31'h0, k != 4});
`else
            chk("sv_iaok", {31'h0, bus.inst_addr_ok}, 32'h0);
            chk("sv_daok", {31'h0, bus.data_addr_ok}, 32'h1);
`endif
            if (bus.inst_addr_ok) n_inst++;
            step();
        end
`ifdef ARB_STARVE_GUARD_EN
        chk("sv_ninst", 32'(n_inst), 32'h1);
`else
        chk("sv_ninst", 32'(n_inst), 32'h0);
`endif
        idle();
        step();

        // Reset while an IF read is in flight: its response must vanish
        bus.inst_req = 1'b1; bus.inst_addr = 32'h1C000000;
        #1;
        chk("rm_iaok", {31'h0, bus.inst_addr_ok}, 32'h1);
        step();
        idle();
        reset = 1'b1;
        #1;
        chk("rm_iok1", {31'h0, bus.inst_data_ok}, 32'h0);
        chk("rm_ird1", bus.inst_rdata,            32'h0);
        chk("rm_en1",  {31'h0, bus.sram_en},      32'h0);
        step();
        reset = 1'b0;
        #1;
        chk("rm_iok2", {31'h0, bus.inst_data_ok}, 32'h0);
        chk("rm_dok2", {31'h0, bus.data_data_ok}, 32'h0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
